led_rotate_ctrl: RTL
====================

# led_rotate_ctrl

Sequencer for the 10-digit circulating LED datapath. It turns a raw push-button, an auto-run enable, a direction request and a speed select into a clean single-cycle `rotate` strobe and a stable `up` direction for the datapath's `clk` domain. It also tracks which digit currently sits in the `d3` position. It sits between the board I/O and the rotating register. The datapath's `key_enable` is tied 0, so all motion goes through `rotate`.

## Interface
- `DB_CYCLES`, default 1_000_000: cycles `key_raw` must be stable before the debounced level changes (20 ms at 50 MHz).
- `TICK_BASE`, default 5_000_000: base auto-step period in cycles.
- `CNT_W`, default 27: width of the prescaler and debounce counters. Must hold `TICK_BASE*8-1` and `DB_CYCLES`.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `key_raw` in 1: raw button, asynchronous, bouncy.
- `auto_en` in 1: level; 1 enables auto-run mode.
- `dir_req` in 1: requested direction; 1 means up (digits advance toward `d3`).
- `speed_sel` in 2: auto step period is `TICK_BASE << (3 - speed_sel)`. 3 is the fastest setting.
- `rotate` out 1: single-cycle step strobe to the datapath.
- `up` out 1: direction paired with `rotate`.
- `head` out 4: digit currently at `d3`, range 0..9.
- `state` out 2: FSM state encoding, for debug and LEDs.

## Operation
- Key path:
  - 2-FF synchronizer, then the debounce counter.
  - The counter resets on any change of the synced level.
  - When it reaches `DB_CYCLES`, the debounced level takes the synced value.
  - `press` is a 1-cycle pulse on the rising edge of the debounced level.
- FSM states:
  - IDLE = 0, RUN = 1, HOLD = 2. Encoding 3 is illegal and recovers to IDLE.
- FSM transitions:
  - IDLE: `auto_en`=1 goes to RUN. `press` issues one step and stays in IDLE.
  - RUN: `press` goes to HOLD. A prescaler tick issues one step.
  - HOLD: `press` goes back to RUN. No steps are issued.
  - Any state: `auto_en`=0 forces IDLE. This has priority over `press` and tick.
- Prescaler:
  - Counts 0..P-1 only in RUN. Tick fires at count P-1, then the count wraps to 0.
  - Clears to 0 on entry to RUN, on any `speed_sel` change, and in any non-RUN state.
- Step issue:
  - `rotate` and `up` are registered together.
  - On a step: `rotate`<=1 and `up`<=`dir_req`.
  - Otherwise: `rotate`<=0 and `up` holds its value.
  - `up` never changes in a cycle where `rotate`=0.
- Head tracking, on each `rotate`=1 cycle:
  - `up`=1: `head` = (`head`+1) mod 10.
  - `up`=0: `head` = (`head`+9) mod 10.
  - `head` updates on the same edge the datapath shifts.
- Simultaneous events:
  - In RUN, `press` and tick in the same cycle: `press` wins. Go to HOLD, no step.
  - `auto_en` falling in the same cycle as a tick: no step.
- Reset values, held while `reset`=1:
  - `rotate`=0, `up`=1, `head`=0, `state`=IDLE.
  - Synchronizer, debounced level and all counters are 0.

## Timing
- Key latency: `key_raw` rising and then held stable gives `rotate`=1 exactly 2+`DB_CYCLES`+2 cycles later.
  - 2 cycles for the synchronizer.
  - `DB_CYCLES` to debounce.
  - 1 cycle for the `press` edge.
  - 1 cycle for the registered strobe.
- Auto rate: in steady RUN, `rotate` pulses every P cycles. The first pulse comes P+1 cycles after the `state` becomes RUN.
- `rotate` is never high for 2 consecutive cycles at any parameter setting with `TICK_BASE`≥1.
- Reset mid-operation: outputs drop to their reset values asynchronously. There is no partial step after reset is released.

## Structure
- Shared package `led_pkg`:
  - State encodings IDLE/RUN/HOLD.
  - `NUM_DIGITS` = 10.
  - `DIGIT_W` = 4.
- Sub-module `key_debounce`: synchronizer, debounce counter and rising-edge `press` output, parameterized by `DB_CYCLES`. It is reused for other board buttons.
- The FSM, prescaler, step register and head counter live in `led_rotate_ctrl`.

## Test plan
All scenarios use `DB_CYCLES`=4 and `TICK_BASE`=3.
- Reset released, then `key_raw`=1 held with `auto_en`=0 and `dir_req`=1: a single `rotate` pulse 8 cycles after `key_raw` rises, with `up`=1 and `head` 0→1. No further pulses.
- Bouncy key (1-0-1 at 2-cycle spacing, then stable 1): exactly one `rotate` pulse.
- `auto_en`=1 with `speed_sel`=3: `rotate` every 3 cycles, `head` counts 1..9,0 (wrap-around). Set `speed_sel`=0: the period becomes 24 cycles and the prescaler restarts.
- RUN with `dir_req` toggled between ticks: `up` changes only on the `rotate` cycles. `dir_req`=0 gives `head` 0→9.
- Press aligned with a tick in RUN: no `rotate`, `state`=HOLD. The next press resumes RUN. `auto_en`=0 in HOLD goes to IDLE.
- Assert `reset` while in RUN mid-count: immediately `rotate`=0, `up`=1, `head`=0, `state`=0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the circulating LED datapath controllers.
package led_pkg;

  localparam int NUM_DIGITS = 10;
  localparam int DIGIT_W    = 4;

  localparam logic [DIGIT_W-1:0] HEAD_LAST = DIGIT_W'(NUM_DIGITS - 1);

  // BAD is never entered on purpose; it exists so a corrupted register has a named recovery path.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    BAD  = 2'd3
  } state_t;

  // Digit index after one step of the ring, modulo NUM_DIGITS.
  function automatic logic [DIGIT_W-1:0] head_next(input logic [DIGIT_W-1:0] h, input logic up);
    if (up) return (h >= HEAD_LAST) ? '0 : h + DIGIT_W'(1);
    else    return (h == '0) ? HEAD_LAST : h - DIGIT_W'(1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: synchronizer, stability counter, rising-edge press pulse.
module key_debounce #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic press
);

  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_CYCLES);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic             db_q;
  logic             db_prev;

  // Two-flop synchronizer; sync_q[1] is the synced level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], key_raw};
  end

  // Stability counter: restarts on the edge the synced level changes, saturates at DB_MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       cnt <= '0;
    else if (sync_q[0] != sync_q[1]) cnt <= '0;
    else if (cnt != DB_MAX)          cnt <= cnt + CNT_W'(1);
  end

  // Debounced level adopts the synced level once it has been stable long enough.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_q    <= 1'b0;
      db_prev <= 1'b0;
    end else begin
      db_prev <= db_q;
      if (cnt == DB_MAX) db_q <= sync_q[1];
    end
  end

  assign press = db_q & ~db_prev;

endmodule

// File: rtl/led_rotate_ctrl.sv
// Step sequencer for the rotating LED register: manual/auto stepping, direction, head tracking.
module led_rotate_ctrl
  import led_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000,
  parameter int TICK_BASE = 5_000_000,
  parameter int CNT_W     = 27
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_raw,
  input  logic               auto_en,
  input  logic               dir_req,
  input  logic [1:0]         speed_sel,
  output logic               rotate,
  output logic               up,
  output logic [DIGIT_W-1:0] head,
  output logic [1:0]         state
);

  logic             press;
  state_t           st, st_nxt;
  logic             step;
  logic             run_q;
  logic [1:0]       spd_q;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] period;
  logic             cnt_en;
  logic             wrap;
  logic             tick;

  key_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_key (
    .clk     (clk),
    .reset   (reset),
    .key_raw (key_raw),
    .press   (press)
  );

  assign period = CNT_W'(TICK_BASE) << (2'd3 - speed_sel);

  // The first RUN cycle and any speed change hold the prescaler at zero, so the
  // first step lands P+1 cycles after entering RUN.
  assign cnt_en = (st == RUN) && run_q && (speed_sel == spd_q);
  assign wrap   = cnt_en && (pcnt == period - CNT_W'(1));
  // Suppressing a tick right after a step keeps rotate from going high twice in a row when P=1.
  assign tick   = wrap && !rotate;

  // Prescaler plus the history it needs to detect RUN entry and speed changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt  <= '0;
      run_q <= 1'b0;
      spd_q <= 2'd0;
    end else begin
      run_q <= (st == RUN);
      spd_q <= speed_sel;
      pcnt  <= (cnt_en && !wrap) ? pcnt + CNT_W'(1) : '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= IDLE;
    else       st <= st_nxt;
  end

  // Next state and step decision; dropping auto_en outranks press and tick.
  always_comb begin
    st_nxt = st;
    step   = 1'b0;
    unique case (st)
      IDLE: begin
        step = press;
        if (auto_en) st_nxt = RUN;
      end
      RUN: begin
        if (!auto_en)  st_nxt = IDLE;
        else if (press) st_nxt = HOLD;
        else if (tick)  step = 1'b1;
      end
      HOLD: begin
        if (!auto_en)   st_nxt = IDLE;
        else if (press) st_nxt = RUN;
      end
      default: st_nxt = IDLE;
    endcase
  end

  // Strobe and direction are registered together; up only moves with a step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rotate <= 1'b0;
      up     <= 1'b1;
    end else begin
      rotate <= step;
      if (step) up <= dir_req;
    end
  end

  // Head follows the datapath: it moves on the same edge that samples rotate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       head <= '0;
    else if (rotate) head <= head_next(head, up);
  end

  assign state = st;

endmodule
